// File: rtl/ram_access_ctrl.sv
// Request-buffering front end for the Hack RAM block. Requests are queued in a small FIFO
// and issued one per cycle. Read data is returned with its address, and a clear sequence
// sweeps zeros into every RAM word.
module ram_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic                  hold_i,
    input  logic                  init_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rsp_valid_o,
    output logic [ADDR_WIDTH-1:0] rsp_addr_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [DATA_WIDTH-1:0] ram_in_o,
    output logic                  ram_load_o,
    output logic [ADDR_WIDTH-1:0] ram_address_o,
    input  logic [DATA_WIDTH-1:0] ram_out_i
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned EntW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [EntW-1:0]       fifo_q [FIFO_DEPTH];
    logic [PtrW:0]         wr_ptr_q, rd_ptr_q;

    logic                  rd_pend_q;
    logic                  ram_load_q, rsp_valid_q, done_q;
    logic [ADDR_WIDTH-1:0] ram_address_q, rsp_addr_q;
    logic [DATA_WIDTH-1:0] ram_in_q, rsp_data_q;

    logic                  empty, full, push, issue, sweep, last_sweep;
    logic [EntW-1:0]       head;
    logic                  head_we;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign head      = fifo_q[rd_ptr_q[PtrW-1:0]];
    assign head_we   = head[EntW-1];
    assign head_addr = head[DATA_WIDTH +: ADDR_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    // Gated by rst_ni so every output reads 0 while reset is held.
    assign req_ready_o = rst_ni && !full && (state_q == StIdle);
    assign push        = req_valid_i && req_ready_o;
    assign issue       = (state_q != StClear) && !hold_i && !empty;
    assign sweep       = (state_q == StClear) && !hold_i;
    assign last_sweep  = sweep && (cnt_q == {ADDR_WIDTH{1'b1}});

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q[PtrW-1:0]] <= {req_we_i, req_addr_i, req_data_i};
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Mode sequencing and sweep counter next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (init_i) state_d = StDrain;
            end
            StDrain: begin
                if (empty) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (sweep) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_sweep) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM port drive and read-response capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ram_load_q    <= 1'b0;
            ram_address_q <= '0;
            ram_in_q      <= '0;
            rd_pend_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            ram_load_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            rsp_valid_q <= rd_pend_q;
            done_q      <= last_sweep;
            // The read presented last cycle is sampled now, before the port moves on.
            if (rd_pend_q) begin
                rsp_addr_q <= ram_address_q;
                rsp_data_q <= ram_out_i;
            end
            if (sweep) begin
                ram_address_q <= cnt_q;
                ram_in_q      <= '0;
                ram_load_q    <= 1'b1;
            end else if (issue) begin
                ram_address_q <= head_addr;
                ram_in_q      <= head_data;
                ram_load_q    <= head_we;
                rd_pend_q     <= !head_we;
            end
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_addr_o    = rsp_addr_q;
    assign rsp_data_o    = rsp_data_q;
    assign ram_in_o      = ram_in_q;
    assign ram_load_o    = ram_load_q;
    assign ram_address_o = ram_address_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a transaction-level model with an attached RAM.
module tb_ram_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_addr_i = '0;
    logic [15:0] req_data_i = '0;
    logic        hold_i = 1'b0;
    logic        init_i = 1'b0;
    logic        busy_o, done_o, rsp_valid_o, ram_load_o;
    logic [2:0]  rsp_addr_o, ram_address_o;
    logic [15:0] rsp_data_o, ram_in_o, ram_out_i;

    int checks = 0;
    int errors = 0;

    ram_access_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .hold_i(hold_i), .init_i(init_i), .busy_o(busy_o), .done_o(done_o),
        .rsp_valid_o(rsp_valid_o), .rsp_addr_o(rsp_addr_o), .rsp_data_o(rsp_data_o),
        .ram_in_o(ram_in_o), .ram_load_o(ram_load_o), .ram_address_o(ram_address_o),
        .ram_out_i(ram_out_i)
    );

    always #5 clk_i = ~clk_i;

    // Attached Hack RAM: combinational read, write on rising edge when load is high.
    logic [15:0] ram [0:7] = '{default: '0};
    assign ram_out_i = ram[ram_address_o];
    always @(posedge clk_i) if (ram_load_o) ram[ram_address_o] <= ram_in_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {bit we; bit [2:0] addr; bit [15:0] data;} req_t;
    req_t        q[$];
    bit [15:0]   m [8] = '{default: '0};
    int          mode;        // 0 accepting, 1 draining, 2 sweeping
    int          sweep_idx;
    bit          rd_outstanding;
    bit [2:0]    rd_outstanding_addr;
    bit          e_load, e_rv, e_done;
    bit [2:0]    e_addr, e_raddr;
    bit [15:0]   e_in, e_rdata;

    function automatic void model_reset();
        q.delete();
        mode = 0; sweep_idx = 0; rd_outstanding = 0; rd_outstanding_addr = 0;
        e_load = 0; e_rv = 0; e_done = 0; e_addr = 0; e_raddr = 0; e_in = 0; e_rdata = 0;
    endfunction

    initial model_reset();

    function automatic void model_edge(bit valid, bit we, bit [2:0] addr, bit [15:0] data,
                                       bit hold, bit init);
        bit   accept;
        bit   was_empty;
        int   old_mode;
        req_t r;
        accept    = valid && (mode == 0) && (q.size() < 4);
        was_empty = (q.size() == 0);
        old_mode  = mode;
        // Response for the read that was on the RAM port during the past cycle.
        e_rv = rd_outstanding;
        if (rd_outstanding) begin
            e_raddr = rd_outstanding_addr;
            e_rdata = m[rd_outstanding_addr];
        end
        rd_outstanding = 0;
        e_done = 0;
        e_load = 0;
        if (old_mode == 2) begin
            if (!hold) begin
                e_load = 1; e_addr = sweep_idx[2:0]; e_in = 0; m[sweep_idx] = 0;
                if (sweep_idx == 7) begin
                    mode = 0; e_done = 1; sweep_idx = 0;
                end else begin
                    sweep_idx++;
                end
            end
        end else if (!hold && !was_empty) begin
            r = q.pop_front();
            e_load = r.we; e_addr = r.addr; e_in = r.data;
            if (r.we) m[r.addr] = r.data;
            else begin
                rd_outstanding = 1; rd_outstanding_addr = r.addr;
            end
        end
        if (old_mode == 0 && init) mode = 1;
        else if (old_mode == 1 && was_empty) begin
            mode = 2; sweep_idx = 0;
        end
        if (accept) begin
            r.we = we; r.addr = addr; r.data = data;
            q.push_back(r);
        end
    endfunction

    // Compare process: advance the model on each edge, then check every output.
    always @(posedge clk_i) begin
        if (!rst_ni) model_reset();
        else model_edge(req_valid_i, req_we_i, req_addr_i, req_data_i, hold_i, init_i);
        #1;
        chk("ram_load", ram_load_o, e_load);
        chk("ram_address", ram_address_o, e_addr);
        chk("ram_in", ram_in_o, e_in);
        chk("rsp_valid", rsp_valid_o, e_rv);
        chk("rsp_addr", rsp_addr_o, e_raddr);
        chk("rsp_data", rsp_data_o, e_rdata);
        chk("done", done_o, e_done);
        chk("busy", busy_o, (rst_ni && mode != 0));
        chk("req_ready", req_ready_o, (rst_ni && mode == 0 && q.size() < 4));
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        req_valid_i = 0; init_i = 0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send(input bit we, input bit [2:0] addr, input bit [15:0] data);
        req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_data_i = data;
        @(negedge clk_i);
        req_valid_i = 0;
    endtask

    initial begin
        int acc;
        int n;
        int dcnt;
        bit found;
        // Reset for 5 cycles.
        repeat (5) @(negedge clk_i);
        chk("reset_load", ram_load_o, 0);
        chk("reset_ready", req_ready_o, 0);
        rst_ni = 1;
        #1;
        chk("post_reset_ready", req_ready_o, 1);
        chk("post_reset_busy", busy_o, 0);
        chk("post_reset_rsp", rsp_valid_o, 0);
        @(negedge clk_i);

        // Write then read back.
        send(1, 3, 7);
        send(0, 3, 0);
        idle(4);
        chk("wr_rd_addr", rsp_addr_o, 3);
        chk("wr_rd_data", rsp_data_o, 7);

        // Ordering.
        send(1, 3, 7);
        send(1, 3, 2);
        send(0, 1, 0);
        send(0, 3, 0);
        idle(5);
        chk("order_addr", rsp_addr_o, 3);
        chk("order_data", rsp_data_o, 2);

        // Full with hold.
        hold_i = 1; acc = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid_i = 1; req_we_i = i[0]; req_addr_i = 3'(i + 4); req_data_i = 16'(i + 40);
            if (req_ready_o) acc++;
            if (i < 4) @(negedge clk_i);
        end
        chk("full_accepts", acc, 4);
        chk("full_ready", req_ready_o, 0);
        hold_i = 0;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        chk("full_release_ready", req_ready_o, 1);
        @(negedge clk_i);
        idle(8);

        // Clear sequence with 2 queued requests.
        send(1, 2, 99);
        idle(3);
        hold_i = 1;
        send(0, 5, 0);
        send(1, 6, 1);
        init_i = 1;
        @(negedge clk_i);
        init_i = 0;
        chk("clear_busy", busy_o, 1);
        chk("clear_ready", req_ready_o, 0);
        hold_i = 0;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (done_o) dcnt++;
        end
        chk("clear_done_count", dcnt, 1);
        chk("clear_busy_end", busy_o, 0);
        send(0, 2, 0);
        idle(4);
        chk("clear_rd_addr", rsp_addr_o, 2);
        chk("clear_rd_data", rsp_data_o, 0);

        // Reset in the middle of a sweep.
        send(1, 4, 16'h55);
        init_i = 1;
        @(negedge clk_i);
        init_i = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk_i);
            if (ram_load_o && ram_address_o == 3'd4 && busy_o) found = 1;
        end
        chk("sweep_reach_4", found, 1);
        #2 rst_ni = 0;
        #1;
        chk("midrst_load", ram_load_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_addr", ram_address_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        #1;
        chk("midrst_ready", req_ready_o, 1);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            req_valid_i = ($urandom_range(0, 99) < 60);
            req_we_i    = $urandom_range(0, 1);
            req_addr_i  = 3'($urandom_range(0, 7));
            req_data_i  = 16'($urandom);
            hold_i      = ($urandom_range(0, 99) < 20);
            init_i      = ($urandom_range(0, 99) < 3);
            @(negedge clk_i);
        end
        hold_i = 0;
        idle(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
